stage_ex_muldiv: RTL and testbench

Multi-cycle RV32M execute unit that sits beside the single-cycle ALU in the EX stage. It accepts one multiply/divide/remainder operation at a time through a valid/ready handshake and raises `stall_o` to freeze the front of the pipeline while busy. It returns the result with its destination register one cycle-exact latency later. It is parametrised in data width and multiplier latency, and supports flush for branch mispredicts.

---
 rtl/stage_ex_muldiv_if.sv | 28 ++
 rtl/stage_ex_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_stage_ex_muldiv.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ex_muldiv_if.sv
// Handshake and result bus between the EX stage and the multi-cycle mul/div unit.
// slave = the unit, master = the pipeline driving it.
interface stage_ex_muldiv_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [2:0]            op_i;
  logic [XLEN-1:0]       rs1_data_i;
  logic [XLEN-1:0]       rs2_data_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  out_valid_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       rd_data_o;
  logic                  stall_o;

  modport slave (
    input  flush_i, in_valid_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output in_ready_o, out_valid_o, rd_addr_o, rd_data_o, stall_o
  );

  modport master (
    output flush_i, in_valid_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  in_ready_o, out_valid_o, rd_addr_o, rd_data_o, stall_o
  );
endinterface

// File: rtl/stage_ex_muldiv.sv
// RV32M multi-cycle execute unit: counted-latency multiply and restoring divide.
//   state | meaning
//   IDLE  | waiting for an op
//   MUL   | product settling, down-counter runs MUL_LAT cycles
//   DIV   | one quotient bit per cycle, XLEN iterations
//   DONE  | result registered, out_valid_o pulses unless flushed
module stage_ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  stage_ex_muldiv_if.slave   bus
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]            op_q;
  logic [XLEN-1:0]       rs1_q, rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       rem_q, quo_q, dvsr_q;
  logic                  neg_quo_q, neg_rem_q;
  logic [XLEN-1:0]       res_q;
  logic [REG_ADDR_W-1:0] res_rd_q;

  logic                  ready, accept;
  logic                  in_is_div, in_signed_div, in_div_zero, in_div_ovf, in_special;
  logic                  in_a_neg, in_b_neg;
  logic [XLEN-1:0]       special_res;
  state_t                start_state;

  logic                  ms1, ms2;
  logic [2*XLEN-1:0]     mul_a, mul_b, prod;
  logic [XLEN-1:0]       mul_res;

  logic [XLEN:0]         rem_shift;
  logic                  div_ge;
  logic [XLEN-1:0]       rem_nxt, quo_nxt, quo_fix, rem_fix, div_res;

  logic                  load_mul, load_div;

  // Accept-side decode, including divide special cases resolved without iterating.
  always_comb begin
    ready         = !rst_in && !bus.flush_i && (state_q == S_IDLE || state_q == S_DONE);
    accept        = bus.in_valid_i && ready;
    in_is_div     = bus.op_i[2];
    in_signed_div = !bus.op_i[0];
    in_div_zero   = (bus.rs2_data_i == '0);
    in_div_ovf    = in_signed_div && (bus.rs1_data_i == SMIN) && (bus.rs2_data_i == '1);
    in_special    = in_is_div && (in_div_zero || in_div_ovf);
    in_a_neg      = in_signed_div && bus.rs1_data_i[XLEN-1];
    in_b_neg      = in_signed_div && bus.rs2_data_i[XLEN-1];
    if (in_div_zero) begin
      special_res = bus.op_i[1] ? bus.rs1_data_i : '1;
    end else begin
      special_res = bus.op_i[1] ? '0 : bus.rs1_data_i;
    end
    if (!in_is_div) begin
      start_state = S_MUL;
    end else if (in_special) begin
      start_state = S_DONE;
    end else begin
      start_state = S_DIV;
    end
  end

  // Operands sign/zero-extended to 2*XLEN; the low 2*XLEN product bits are exact.
  always_comb begin
    ms1     = (op_q == 2'b01) || (op_q == 2'b10);
    ms2     = (op_q == 2'b01);
    mul_a   = {{XLEN{ms1 & rs1_q[XLEN-1]}}, rs1_q};
    mul_b   = {{XLEN{ms2 & rs2_q[XLEN-1]}}, rs2_q};
    prod    = mul_a * mul_b;
    mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // quo_q starts as the dividend magnitude and is shifted out as quotient bits enter.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    div_ge    = (rem_shift >= {1'b0, dvsr_q});
    rem_nxt   = div_ge ? XLEN'(rem_shift - {1'b0, dvsr_q}) : rem_shift[XLEN-1:0];
    quo_nxt   = {quo_q[XLEN-2:0], div_ge};
    quo_fix   = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix   = neg_rem_q ? -rem_nxt : rem_nxt;
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d  = state_q;
    load_mul = 1'b0;
    load_div = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = start_state;
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          load_mul = !bus.flush_i;
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          load_div = !bus.flush_i;
        end
      end
      S_DONE: state_d = accept ? start_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      res_rd_q  <= '0;
    end else begin
      if (bus.flush_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        op_q      <= bus.op_i[1:0];
        rs1_q     <= bus.rs1_data_i;
        rs2_q     <= bus.rs2_data_i;
        rd_q      <= bus.rd_addr_i;
        cnt_q     <= in_is_div ? DIV_LOAD : MUL_LOAD;
        rem_q     <= '0;
        quo_q     <= in_a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
        dvsr_q    <= in_b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
        neg_quo_q <= in_a_neg ^ in_b_neg;
        neg_rem_q <= in_a_neg;
      end else if (state_q == S_MUL || state_q == S_DIV) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        if (state_q == S_DIV) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
        end
      end

      if (load_mul) begin
        res_q    <= mul_res;
        res_rd_q <= rd_q;
      end else if (load_div) begin
        res_q    <= div_res;
        res_rd_q <= rd_q;
      end else if (accept && in_special) begin
        res_q    <= special_res;
        res_rd_q <= bus.rd_addr_i;
      end
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.out_valid_o = (state_q == S_DONE) && !bus.flush_i;
  assign bus.stall_o     = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.rd_addr_o   = res_rd_q;
  assign bus.rd_data_o   = res_q;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Directed and random checks of stage_ex_muldiv against an arithmetic RV32M reference.
module tb_stage_ex_muldiv;
  localparam int XLEN = 32;
  localparam int RW = 5;
  localparam int MUL_LAT = 2;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_ex_muldiv_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
  stage_ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RW), .MUL_LAT(MUL_LAT)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] up;
    longint p;
    int sa, sb;
    up = {32'b0, a} * {32'b0, b};
    sa = a;
    sb = b;
    case (op)
      3'd0: return up[31:0];
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 0;
    if (!op[0] && a == SMIN && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.op_i = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i = rd;
    bus.in_valid_i = 1'b1;
    #1;
    check("in_ready", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int stalls);
    bit seen;
    seen = 1'b0;
    lat = 0;
    stalls = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      if (bus.out_valid_o === 1'b1) seen = 1'b1;
      else begin
        if (bus.stall_o === 1'b1) stalls++;
        lat++;
      end
    end
    check("result_seen", 64'(seen), 64'd1);
  endtask

  task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input int lat, input int stalls);
    check("latency", 64'(lat), 64'(ref_latency(op, a, b)));
    check("stall_cycles", 64'(stalls), 64'(ref_latency(op, a, b)));
    check("rd_data", 64'(bus.rd_data_o), 64'(ref_result(op, a, b)));
    check("rd_addr", 64'(bus.rd_addr_o), 64'(rd));
    check("stall_in_done", 64'(bus.stall_o), 64'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int lat, stalls;
    @(negedge clk);
    present(op, a, b, rd);
    wait_result(lat, stalls);
    expect_op(op, a, b, rd, lat, stalls);
    @(negedge clk);
    check("valid_one_cycle", 64'(bus.out_valid_o), 64'd0);
  endtask

  initial begin
    int lat, stalls, count;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.op_i = 3'd0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.rd_addr_i = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.in_ready_o), 64'd0);
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_data", 64'(bus.rd_data_o), 64'd0);
    check("rst_addr", 64'(bus.rd_addr_o), 64'd0);
    rst = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    do_op(3'd1, SMIN, SMIN, 5'd2);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);
    do_op(3'd5, 32'd100, 32'd7, 5'd5);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
    do_op(3'd4, 32'd5, 32'd0, 5'd8);
    do_op(3'd7, 32'd5, 32'd0, 5'd9);
    do_op(3'd4, SMIN, 32'hFFFF_FFFF, 5'd10);
    do_op(3'd6, SMIN, 32'hFFFF_FFFF, 5'd11);

    // flush at DIV iteration 10
    @(negedge clk);
    present(3'd4, 32'd1000, 32'd3, 5'd12);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    check("flush_div_valid", 64'(bus.out_valid_o), 64'd0);
    check("flush_div_ready", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_div_stall", 64'(bus.stall_o), 64'd0);
    check("flush_div_ready_after", 64'(bus.in_ready_o), 64'd1);
    count = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid_o === 1'b1) count++; end
    check("flush_div_no_result", 64'(count), 64'd0);

    // flush during DONE, with a new op offered in the same cycle
    @(negedge clk);
    present(3'd0, 32'd3, 32'd5, 5'd13);
    repeat (3) @(negedge clk);
    check("done_reached", 64'(bus.stall_o), 64'd0);
    bus.flush_i = 1'b1;
    bus.in_valid_i = 1'b1;
    #1;
    check("flush_done_valid", 64'(bus.out_valid_o), 64'd0);
    check("flush_done_ready", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    count = 0;
    repeat (10) begin @(negedge clk); if (bus.out_valid_o === 1'b1 || bus.stall_o === 1'b1) count++; end
    check("flush_done_quiet", 64'(count), 64'd0);

    // back-to-back: MULHU issued in the DONE cycle of a DIVU
    @(negedge clk);
    present(3'd5, 32'd1_000_003, 32'd13, 5'd14);
    wait_result(lat, stalls);
    expect_op(3'd5, 32'd1_000_003, 32'd13, 5'd14, lat, stalls);
    present(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);
    @(negedge clk);
    check("b2b_no_bubble", 64'(bus.stall_o), 64'd1);
    lat = 1;
    stalls = 1;
    while (bus.out_valid_o !== 1'b1 && lat < 60) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b1) begin lat++; if (bus.stall_o === 1'b1) stalls++; end
    end
    expect_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15, lat, stalls);

    // reset in the middle of a divide
    @(negedge clk);
    present(3'd4, 32'd77777, 32'd5, 5'd16);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 64'(bus.in_ready_o), 64'd0);
    @(negedge clk);
    check("midrst_valid", 64'(bus.out_valid_o), 64'd0);
    check("midrst_stall", 64'(bus.stall_o), 64'd0);
    check("midrst_data", 64'(bus.rd_data_o), 64'd0);
    check("midrst_addr", 64'(bus.rd_addr_o), 64'd0);
    rst = 1'b0;
    do_op(3'd6, 32'hFFFF_0000, 32'd12345, 5'd17);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = SMIN; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
